// File: rtl/auth_rx.sv
// 8N1 UART receiver with go/stop command authorization driving pwr_up.
// pwr_up drops only after a stop byte and once the rider is off the platform.
//
//   rx state | meaning
//   IDLE     | waiting for a start edge on rx_s
//   START    | half-bit wait, then confirm the start bit is still low
//   DATA     | sampling 8 data bits at mid-bit, LSB first
//   STOP     | sampling the stop bit
//   BRK      | stop bit was low; wait for the line to return high
//
//   auth state | meaning
//   OFF        | not powered
//   PWR1       | powered, no stop pending
//   PWR2       | powered, stop received, waiting for rider_off
module auth_rx #(
    parameter int          BAUD_DIV = 2604,
    parameter logic [7:0]  GO_CMD   = 8'h67,
    parameter logic [7:0]  STOP_CMD = 8'h73
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    localparam int CW = 12;
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LD  = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BRK
    } rx_state_t;

    typedef enum logic [1:0] {
        A_OFF,
        A_PWR1,
        A_PWR2
    } auth_state_t;

    rx_state_t   rx_st_q, rx_st_d;
    auth_state_t auth_q, auth_d;

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [1:0]    init_q, init_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_rdy_q, rx_rdy_d;
    logic          frm_err_q, frm_err_d;
    logic          pwr_up_q, pwr_up_d;
    logic          rx_fall;
    logic          tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            init_q    <= 2'b00;
            armed_q   <= 1'b0;
            rx_st_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            rx_data_q <= '0;
            rx_rdy_q  <= 1'b0;
            frm_err_q <= 1'b0;
            auth_q    <= A_OFF;
            pwr_up_q  <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            init_q    <= init_d;
            armed_q   <= armed_d;
            rx_st_q   <= rx_st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rx_data_q <= rx_data_d;
            rx_rdy_q  <= rx_rdy_d;
            frm_err_q <= frm_err_d;
            auth_q    <= auth_d;
            pwr_up_q  <= pwr_up_d;
        end
    end

    // The preset synchronizer would fake a falling edge if RX is low at reset
    // release; only arm edge detection once rx_s has been seen high for real.
    always_comb begin
        init_d  = {init_q[0], 1'b1};
        armed_d = armed_q | (init_q[1] & rx_s_q);
        rx_fall = armed_q & rx_prev_q & ~rx_s_q;
        tick    = (cnt_q == '0);
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rx_data_d = rx_data_q;
        rx_rdy_d  = 1'b0;
        frm_err_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    cnt_d   = HALF_LD;
                    rx_st_d = RX_START;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    cnt_d   = BIT_LD;
                    bit_d   = '0;
                    rx_st_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sh_d  = {rx_s_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    cnt_d = BIT_LD;
                    if (bit_q == 4'd7) begin
                        rx_st_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    rx_data_d = sh_q;
                    rx_rdy_d  = 1'b1;
                    rx_st_d   = RX_IDLE;
                end else begin
                    frm_err_d = 1'b1;
                    rx_st_d   = RX_BRK;
                end
            end
            RX_BRK: begin
                if (rx_s_q) begin
                    rx_st_d = RX_IDLE;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_comb begin
        auth_d = auth_q;
        case (auth_q)
            A_OFF: begin
                if (rx_rdy_q && rx_data_q == GO_CMD) begin
                    auth_d = A_PWR1;
                end
            end
            A_PWR1: begin
                if (rx_rdy_q && rx_data_q == STOP_CMD) begin
                    auth_d = rider_off ? A_OFF : A_PWR2;
                end
            end
            A_PWR2: begin
                // A go cancels the pending stop even if the rider steps off that cycle.
                if (rx_rdy_q && rx_data_q == GO_CMD) begin
                    auth_d = A_PWR1;
                end else if (rider_off) begin
                    auth_d = A_OFF;
                end
            end
            default: auth_d = A_OFF;
        endcase
        pwr_up_d = (auth_d != A_OFF);
    end

    assign rx_data = rx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign frm_err = frm_err_q;
    assign pwr_up  = pwr_up_q;

endmodule

// File: tb/tb_auth_rx.sv
// Directed bench for auth_rx: framing, latency, go/stop authorization, reset mid-frame.
module tb_auth_rx;

    localparam int B = 32;
    localparam int LAT_NOM = 2 + B / 2 + 9 * B;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       rider_off;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int frm_cnt = 0;
    int last_rdy_cyc = 0;
    int prev_rdy_cyc = 0;
    int start_cyc = 0;
    logic pwr_at_rdy = 1'b0;
    logic pwr_after_rdy = 1'b0;
    logic rdy_d1 = 1'b0;

    auth_rx #(.BAUD_DIV(B), .GO_CMD(8'h67), .STOP_CMD(8'h73)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err),
        .pwr_up    (pwr_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy_d1) pwr_after_rdy = pwr_up;
        if (rx_rdy) begin
            rdy_cnt++;
            prev_rdy_cyc = last_rdy_cyc;
            last_rdy_cyc = cyc;
            pwr_at_rdy   = pwr_up;
        end
        if (frm_err) frm_cnt++;
        rdy_d1 = rx_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge after the stop bit (plus extra low time).
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int hold_bits);
        start_cyc = cyc;
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_bit;
        repeat (B * (1 + hold_bits)) @(negedge clk);
        RX = 1'b1;
    endtask

    initial begin
        int r0;
        int f0;
        int lat;
        int gap;
        bit seen;

        RX = 1'b1;
        rider_off = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_rdy", rx_rdy, 1'b0);
        chk("rst_frm_err", frm_err, 1'b0);
        chk("rst_pwr_up", pwr_up, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // go from OFF
        send_byte(8'h67, 1'b1, 0);
        lat = last_rdy_cyc - start_cyc;
        chk("go_rdy_cnt", rdy_cnt, 1);
        chk("go_latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
        chk("go_data", rx_data, 8'h67);
        chk("go_pwr_at_rdy", pwr_at_rdy, 1'b0);
        chk("go_pwr_next", pwr_after_rdy, 1'b1);
        chk("go_no_frm", frm_cnt, 0);

        // stop with rider on: pending, then rider_off drops pwr_up on the next clock
        send_byte(8'h73, 1'b1, 0);
        chk("stop_pend_data", rx_data, 8'h73);
        chk("stop_pend_pwr", pwr_up, 1'b1);
        rider_off = 1'b1;
        chk("riderop_pwr_same", pwr_up, 1'b1);
        @(negedge clk);
        chk("riderop_pwr_next", pwr_up, 1'b0);
        rider_off = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h67, 1'b1, 0);
        chk("rego_pwr", pwr_up, 1'b1);

        // stop with rider off, then an unrelated byte in OFF
        rider_off = 1'b1;
        send_byte(8'h73, 1'b1, 0);
        chk("stop_off_at_rdy", pwr_at_rdy, 1'b1);
        chk("stop_off_next", pwr_after_rdy, 1'b0);
        r0 = rdy_cnt;
        send_byte(8'h41, 1'b1, 0);
        chk("other_rdy", rdy_cnt, r0 + 1);
        chk("other_data", rx_data, 8'h41);
        chk("other_pwr", pwr_up, 1'b0);

        // glitch shorter than half a bit is a false start
        rider_off = 1'b0;
        r0 = rdy_cnt;
        f0 = frm_cnt;
        RX = 1'b0;
        repeat (B / 2 - 6) @(negedge clk);
        RX = 1'b1;
        repeat (3 * B) @(negedge clk);
        chk("glitch_no_rdy", rdy_cnt, r0);
        chk("glitch_no_frm", frm_cnt, f0);
        send_byte(8'h67, 1'b1, 0);
        chk("glitch_go_data", rx_data, 8'h67);
        chk("glitch_go_pwr", pwr_up, 1'b1);

        // framing error while OFF: byte must not be decoded
        rider_off = 1'b1;
        send_byte(8'h73, 1'b1, 0);
        send_byte(8'h41, 1'b1, 0);
        rider_off = 1'b0;
        r0 = rdy_cnt;
        f0 = frm_cnt;
        send_byte(8'h67, 1'b0, 2);
        chk("ferr_cnt", frm_cnt, f0 + 1);
        chk("ferr_no_rdy", rdy_cnt, r0);
        chk("ferr_data", rx_data, 8'h41);
        chk("ferr_pwr", pwr_up, 1'b0);
        repeat (2 * B) @(negedge clk);
        send_byte(8'h67, 1'b1, 0);
        chk("ferr_recov_data", rx_data, 8'h67);
        chk("ferr_recov_pwr", pwr_up, 1'b1);
        chk("ferr_recov_frm", frm_cnt, f0 + 1);

        // back-to-back go, stop with rider on -> PWR2
        r0 = rdy_cnt;
        send_byte(8'h67, 1'b1, 0);
        send_byte(8'h73, 1'b1, 0);
        gap = last_rdy_cyc - prev_rdy_cyc;
        chk("b2b_rdy_cnt", rdy_cnt, r0 + 2);
        chk("b2b_gap", (gap >= 10 * B - 2 && gap <= 10 * B + 2), 1);
        chk("b2b_data", rx_data, 8'h73);
        chk("b2b_pwr", pwr_up, 1'b1);

        // in PWR2, go and rider_off in the same cycle: go wins
        seen = 1'b0;
        fork
            send_byte(8'h67, 1'b1, 0);
            begin
                for (int i = 0; i < 12 * B && !seen; i++) begin
                    @(negedge clk);
                    if (rx_rdy) begin
                        rider_off = 1'b1;
                        seen = 1'b1;
                    end
                end
            end
        join
        chk("prio_seen_rdy", seen, 1'b1);
        repeat (4) @(negedge clk);
        chk("prio_pwr", pwr_up, 1'b1);
        rider_off = 1'b0;

        // reset in the middle of a frame
        RX = 1'b0;
        repeat (3 * B) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_rdy", rx_rdy, 1'b0);
        chk("midrst_frm", frm_err, 1'b0);
        chk("midrst_pwr", pwr_up, 1'b0);
        @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        r0 = rdy_cnt;
        send_byte(8'h67, 1'b1, 0);
        chk("postrst_rdy", rdy_cnt, r0 + 1);
        chk("postrst_data", rx_data, 8'h67);
        chk("postrst_pwr", pwr_up, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
